instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Per-warp instruction fetch stage feeding the decoder. When the warp enters `WARP_FETCH`, it returns the instruction at `pc` from a small direct-mapped instruction cache or fetches it from program memory through a valid/ready handshake. It then presents a stable `instruction` to the decoder for the `WARP_DECODE` cycle. It sits between the warp scheduler/PC logic and the decoder, and its bus side connects to the program-memory controller.

## Interface
- `PROGRAM_ADDR_BITS`, 12: width of `pc` and `mem_read_address`, in instruction-word units.
- `INSTRUCTION_BITS`, 32: instruction width; must equal the width of `instruction_t`.
- `CACHE_LINES`, 16: number of cache lines. One instruction per line. Power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `warp_state`  in  `warp_state_t`  current warp state; the block acts on `WARP_FETCH` and `WARP_DECODE`.
- `pc`  in  `PROGRAM_ADDR_BITS`  word address of the instruction to fetch.
- `flush`  in  1  invalidates all cache lines.
- `mem_read_valid`  out  1  program-memory read request.
- `mem_read_address`  out  `PROGRAM_ADDR_BITS`  request address.
- `mem_read_ready`  in  1  memory response strobe; `mem_read_data` is valid in the same cycle.
- `mem_read_data`  in  `INSTRUCTION_BITS`  returned instruction word.
- `fetcher_state`  out  3  encoding: IDLE=3'b000, REQUEST=3'b001, FETCHED=3'b010.
- `instruction`  out  `instruction_t`  fetched instruction; held stable until the next fetch completes.

## Operation
- `idx = pc[log2(CACHE_LINES)-1:0]`.
- `tag = pc[PROGRAM_ADDR_BITS-1:log2(CACHE_LINES)]`.
- Cache storage is `valid[CACHE_LINES]`, `tag_mem[CACHE_LINES]` and `data_mem[CACHE_LINES]`.
- IDLE:
  - If `warp_state == WARP_FETCH`, latch `pc` into `fetch_pc`.
  - Hit (`valid[idx]` set and `tag_mem[idx] == tag`): `instruction <= data_mem[idx]`, next state FETCHED.
  - Miss: next state REQUEST.
  - For any other `warp_state`, remain in IDLE.
- REQUEST:
  - `mem_read_valid = 1` and `mem_read_address = fetch_pc`, both driven from registers and held constant until `mem_read_ready`.
  - On `mem_read_ready`: `instruction <= mem_read_data`; write data and tag into line `fetch_pc` index and set its valid bit; `mem_read_valid` deasserts next cycle; next state FETCHED.
  - `warp_state` is ignored while in REQUEST.
- FETCHED:
  - Hold `instruction`.
  - When `warp_state == WARP_DECODE`, go to IDLE.
  - The decoder samples `instruction` in that cycle; it is unchanged by the transition.
- `flush`:
  - Clears every valid bit at the next edge, in any state.
  - If `flush` coincides with a fill, flush wins and the line stays invalid, but `instruction` is still loaded and the FSM still moves to FETCHED.
  - If `flush` coincides with an IDLE lookup, the lookup uses the pre-flush valid bits.
- Eviction: a fill overwrites the line unconditionally. There is no replacement policy (aliasing PCs evict each other).
- Reset values:
  - FSM = IDLE, `fetcher_state = 3'b000`.
  - `mem_read_valid = 0`, `mem_read_address = 0`, `instruction = 0`.
  - All valid bits = 0. Tag and data memories are not reset.
- Reset mid-REQUEST drops `mem_read_valid` combinationally with `reset`. A later `mem_read_ready` is ignored.

## Timing
- Hit: `WARP_FETCH` sampled at edge N; FETCHED with `instruction` valid after edge N.
- Miss:
  - REQUEST after edge N.
  - `mem_read_ready` sampled at edge M, with M ≥ N+1.
  - FETCHED and valid `instruction` after edge M.
  - Minimum miss latency is 2 cycles; there is no upper bound.
- `mem_read_ready` outside REQUEST is ignored.
- At most one outstanding request at a time.
- Back-to-back fetches: FETCHED → IDLE on `WARP_DECODE`; the next `WARP_FETCH` is accepted from IDLE, giving a minimum of 1 idle cycle between fetches.

## Test plan
- Reset, then release with `warp_state` not equal to `WARP_FETCH` for 10 cycles -> all outputs 0, `fetcher_state` 000, no request issued.
- Cold fetch `pc=0x005`, memory answers 3 cycles later with 0x1234_5678 -> `mem_read_valid` high 3 cycles with address 0x005, then FETCHED with `instruction` = 0x12345678, held through `WARP_DECODE`.
- Refetch `pc=0x005` -> no `mem_read_valid`; FETCHED one cycle after `WARP_FETCH` with 0x12345678.
- Fetch `pc=0x015` (same index, tag differs) with data 0xDEAD_BEEF, then `pc=0x005` -> two misses, both instructions correct.
- `flush` asserted in the same cycle as the fill for `pc=0x007` -> `instruction` updates to the fill data; the next fetch of 0x007 misses again.
- Assert `reset` during REQUEST, then pulse `mem_read_ready` -> `mem_read_valid` drops immediately; the ready pulse is ignored; state IDLE; `instruction` stays 0.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Warp instruction fetch: direct-mapped I-cache lookup, program-memory fill on miss.
// Latency: hit 1 cycle, miss 2+ cycles; request held until mem_read_ready.
// Backpressure: warp_state is ignored while a request is outstanding.
package instruction_fetcher_pkg;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_EXECUTE = 3'd3,
        WARP_UPDATE  = 3'd4,
        WARP_DONE    = 3'd5
    } warp_state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] rd;
        logic [7:0] rs1;
        logic [7:0] rs2;
    } instruction_t;

endpackage

module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int PROGRAM_ADDR_BITS = 12,
    parameter int INSTRUCTION_BITS  = 32,
    parameter int CACHE_LINES       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  warp_state_t                  warp_state,
    input  logic [PROGRAM_ADDR_BITS-1:0] pc,
    input  logic                         flush,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [INSTRUCTION_BITS-1:0]  mem_read_data,
    output logic [2:0]                   fetcher_state,
    output instruction_t                 instruction
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_ADDR_BITS - IDX_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        REQUEST = 3'b001,
        FETCHED = 3'b010
    } fetch_state_t;

    fetch_state_t state, state_nxt;

    logic [CACHE_LINES-1:0]       valid;
    logic [TAG_BITS-1:0]          tag_mem  [CACHE_LINES];
    instruction_t                 data_mem [CACHE_LINES];
    logic [PROGRAM_ADDR_BITS-1:0] fetch_pc;

    logic [IDX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] fill_tag;
    logic                lookup_hit;
    logic                fetch_req;
    logic                fill_en;

    assign lookup_idx = pc[IDX_BITS-1:0];
    assign lookup_tag = pc[PROGRAM_ADDR_BITS-1:IDX_BITS];
    assign fill_idx   = fetch_pc[IDX_BITS-1:0];
    assign fill_tag   = fetch_pc[PROGRAM_ADDR_BITS-1:IDX_BITS];
    assign lookup_hit = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign fetch_req  = (state == IDLE) && (warp_state == WARP_FETCH);
    assign fill_en    = (state == REQUEST) && mem_read_ready;

    // The request address is the latched fetch PC, so it stays stable for the whole request.
    assign mem_read_address = fetch_pc;
    assign fetcher_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    state_nxt = lookup_hit ? FETCHED : REQUEST;
                end
            end
            REQUEST: begin
                if (mem_read_ready) begin
                    state_nxt = FETCHED;
                end
            end
            FETCHED: begin
                if (warp_state == WARP_DECODE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc       <= '0;
            mem_read_valid <= 1'b0;
            instruction    <= '0;
            valid          <= '0;
        end else begin
            if (fetch_req) begin
                fetch_pc <= pc;
                if (lookup_hit) begin
                    instruction <= data_mem[lookup_idx];
                end else begin
                    mem_read_valid <= 1'b1;
                end
            end
            if (fill_en) begin
                instruction     <= instruction_t'(mem_read_data);
                mem_read_valid  <= 1'b0;
                valid[fill_idx] <= 1'b1;
            end
            // Flush is last so it overrides a coincident fill's valid bit.
            if (flush) begin
                valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= instruction_t'(mem_read_data);
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: hits, misses, aliasing, flush and reset corner cases.
module tb_instruction_fetcher;
    import instruction_fetcher_pkg::*;

    logic         clk;
    logic         reset;
    warp_state_t  warp_state;
    logic [11:0]  pc;
    logic         flush;
    logic         mem_read_valid;
    logic [11:0]  mem_read_address;
    logic         mem_read_ready;
    logic [31:0]  mem_read_data;
    logic [2:0]   fetcher_state;
    instruction_t instruction;

    int checks   = 0;
    int failures = 0;

    instruction_fetcher #(
        .PROGRAM_ADDR_BITS(12),
        .INSTRUCTION_BITS (32),
        .CACHE_LINES      (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .warp_state      (warp_state),
        .pc              (pc),
        .flush           (flush),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .fetcher_state   (fetcher_state),
        .instruction     (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge with the FSM back in IDLE.
    task automatic do_fetch(input string name, input logic [11:0] addr, input bit hit,
                            input logic [31:0] data, input int lat, input bit flush_fetch,
                            input bit flush_fill);
        warp_state = WARP_FETCH;
        pc         = addr;
        flush      = flush_fetch;
        @(negedge clk);
        warp_state = WARP_EXECUTE;
        flush      = 1'b0;
        if (hit) begin
            check({name, "_hit_state"}, {29'd0, fetcher_state}, 32'h2);
            check({name, "_hit_noreq"}, {31'd0, mem_read_valid}, 32'h0);
        end else begin
            for (int i = 1; i <= lat; i++) begin
                check({name, "_req_state"}, {29'd0, fetcher_state}, 32'h1);
                check({name, "_req_valid"}, {31'd0, mem_read_valid}, 32'h1);
                check({name, "_req_addr"}, {20'd0, mem_read_address}, {20'd0, addr});
                if (i == lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = data;
                    flush          = flush_fill;
                end
                @(negedge clk);
            end
            mem_read_ready = 1'b0;
            mem_read_data  = 32'h0;
            flush          = 1'b0;
            check({name, "_fill_valid_drop"}, {31'd0, mem_read_valid}, 32'h0);
        end
        check({name, "_fetched_state"}, {29'd0, fetcher_state}, 32'h2);
        check({name, "_instr"}, instruction, data);
        @(negedge clk);
        check({name, "_hold_state"}, {29'd0, fetcher_state}, 32'h2);
        check({name, "_hold_instr"}, instruction, data);
        warp_state = WARP_DECODE;
        @(negedge clk);
        warp_state = WARP_IDLE;
        check({name, "_decode_idle"}, {29'd0, fetcher_state}, 32'h0);
        check({name, "_decode_instr"}, instruction, data);
    endtask

    initial begin
        reset          = 1'b1;
        warp_state     = WARP_IDLE;
        pc             = 12'h0;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_state", {29'd0, fetcher_state}, 32'h0);
        check("rst_valid", {31'd0, mem_read_valid}, 32'h0);
        check("rst_addr", {20'd0, mem_read_address}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        reset      = 1'b0;
        warp_state = WARP_EXECUTE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_noreq", {31'd0, mem_read_valid}, 32'h0);
            check("idle_state", {29'd0, fetcher_state}, 32'h0);
        end
        check("idle_instr", instruction, 32'h0);
        warp_state = WARP_IDLE;

        do_fetch("cold_005", 12'h005, 1'b0, 32'h1234_5678, 3, 1'b0, 1'b0);
        do_fetch("hit_005", 12'h005, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0);
        do_fetch("alias_015", 12'h015, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);
        do_fetch("evict_005", 12'h005, 1'b0, 32'h1234_5678, 1, 1'b0, 1'b0);
        do_fetch("rehit_005", 12'h005, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0);
        do_fetch("hit_015_miss", 12'h015, 1'b0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);

        // Fill of 0x007 coincides with flush: data delivered, line stays invalid.
        do_fetch("flushfill_007", 12'h007, 1'b0, 32'hCAFE_F00D, 1, 1'b0, 1'b1);
        do_fetch("refill_007", 12'h007, 1'b0, 32'h0BAD_F00D, 2, 1'b0, 1'b0);
        // Lookup coinciding with flush still sees the old valid bit, then misses afterwards.
        do_fetch("flushlook_007", 12'h007, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 1'b0);
        do_fetch("postflush_007", 12'h007, 1'b0, 32'h7777_0007, 1, 1'b0, 1'b0);

        // Stray ready outside REQUEST is ignored.
        mem_read_ready = 1'b1;
        mem_read_data  = 32'hFFFF_0000;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check("stray_rdy_state", {29'd0, fetcher_state}, 32'h0);
        check("stray_rdy_instr", instruction, 32'h7777_0007);
        check("stray_rdy_valid", {31'd0, mem_read_valid}, 32'h0);

        // Reset in the middle of a request.
        warp_state = WARP_FETCH;
        pc         = 12'h020;
        @(negedge clk);
        warp_state = WARP_IDLE;
        check("midrst_pre_valid", {31'd0, mem_read_valid}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("midrst_valid_drop", {31'd0, mem_read_valid}, 32'h0);
        check("midrst_state", {29'd0, fetcher_state}, 32'h0);
        @(negedge clk);
        reset          = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 32'hABCD_EF01;
        @(negedge clk);
        mem_read_ready = 1'b0;
        check("midrst_rdy_state", {29'd0, fetcher_state}, 32'h0);
        check("midrst_rdy_instr", instruction, 32'h0);
        check("midrst_rdy_valid", {31'd0, mem_read_valid}, 32'h0);
        check("midrst_rdy_addr", {20'd0, mem_read_address}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
